// File: rtl/trig_acq_ctrl_pkg.sv
// Shared types and defaults for the acquisition sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package trig_acq_ctrl_pkg;

   // Default widths for counters and the capture buffer address
   localparam int CNT_W_DEF  = 14;
   localparam int ADDR_W_DEF = 14;
   localparam int HOLD_W_DEF = 16;

   // Sequencer state; encodings are exported through the status register
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_HOLD = 3'd4,
      ST_DONE = 3'd5
   } acq_state_t;

endpackage

// File: rtl/trig_acq_ctrl_edge_det.sv
// Rising-edge detector for a level trigger; one flop of history.
// Latency: edge is combinational from trig against the previous-cycle level.
// Backpressure: none.
module trig_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   output logic trig_edge
);

   logic trig_q;

   // Remember last cycle's trigger level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trig_q <= 1'b0;
      else        trig_q <= trig;
   end

   assign trig_edge = trig & ~trig_q;

endmodule

// File: rtl/trig_acq_ctrl.sv
// Capture sequencer: arm -> pre-fill -> wait trigger -> post count -> hold-off/done.
// Latency: every output is registered; transitions show one cycle after the causing input.
// Backpressure: none; the capture buffer always accepts a write when wr_en_o is high.
module trig_acq_ctrl
   import trig_acq_ctrl_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF
) (
   input  logic              adc_clk,
   input  logic              adc_rstn,
   input  logic              arm_i,
   input  logic              abort_i,
   input  logic              cont_i,
   input  logic              trig_i,
   input  logic [CNT_W-1:0]  pre_len_i,
   input  logic [CNT_W-1:0]  post_len_i,
   input  logic [HOLD_W-1:0] holdoff_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [ADDR_W-1:0] trig_addr_o,
   output logic              trig_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [2:0]        state_o
);

   // One shared down-counter serves PRE, POST and HOLD, so it is as wide as the widest
   localparam int CW = (CNT_W > HOLD_W) ? CNT_W : HOLD_W;
   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   acq_state_t          state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                latch;
   logic                trig_edge;
   logic                cont_q;
   logic [CNT_W-1:0]    pre_q, post_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [ADDR_W-1:0]   wr_addr_nxt;
   logic                enter_post;

   trig_edge_det u_edge (
      .clk       (adc_clk),
      .rst_n     (adc_rstn),
      .trig      (trig_i),
      .trig_edge (trig_edge)
   );

   // Address advances after each written sample and wraps naturally
   assign wr_addr_nxt = wr_addr_o + {{(ADDR_W-1){1'b0}}, wr_en_o};
   assign enter_post  = (state == ST_WAIT) && (state_nxt == ST_POST);

   // Next-state and counter reload; abort overrides every other event
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      latch     = 1'b0;
      if (abort_i) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (arm_i) begin
                  latch = 1'b1;
                  if (pre_len_i == '0) begin
                     state_nxt = ST_WAIT;
                  end else begin
                     state_nxt = ST_PRE;
                     cnt_nxt   = CW'(pre_len_i) - ONE;
                  end
               end
            end
            ST_PRE: begin
               // Trigger edges here are deliberately not looked at
               if (cnt == '0) state_nxt = ST_WAIT;
               else           cnt_nxt   = cnt - ONE;
            end
            ST_WAIT: begin
               if (trig_edge) begin
                  state_nxt = ST_POST;
                  cnt_nxt   = (post_q == '0) ? '0 : CW'(post_q) - ONE;
               end
            end
            ST_POST: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - ONE;
               end else if (!cont_q) begin
                  state_nxt = ST_DONE;
               end else if (hold_q != '0) begin
                  state_nxt = ST_HOLD;
                  cnt_nxt   = CW'(hold_q) - ONE;
               end else if (pre_q == '0) begin
                  state_nxt = ST_WAIT;
               end else begin
                  state_nxt = ST_PRE;
                  cnt_nxt   = CW'(pre_q) - ONE;
               end
            end
            ST_HOLD: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - ONE;
               end else if (pre_q == '0) begin
                  state_nxt = ST_WAIT;
               end else begin
                  state_nxt = ST_PRE;
                  cnt_nxt   = CW'(pre_q) - ONE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, counter, latched config and registered outputs decoded from the next state
   always_ff @(posedge adc_clk or negedge adc_rstn) begin
      if (!adc_rstn) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         cont_q      <= 1'b0;
         pre_q       <= '0;
         post_q      <= '0;
         hold_q      <= '0;
         wr_en_o     <= 1'b0;
         wr_addr_o   <= '0;
         trig_addr_o <= '0;
         trig_o      <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         state_o     <= 3'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wr_addr_o <= wr_addr_nxt;
         if (latch) begin
            cont_q <= cont_i;
            pre_q  <= pre_len_i;
            post_q <= post_len_i;
            hold_q <= holdoff_i;
         end
         // The trigger sample is the write that lands in the first POST cycle
         if (enter_post) trig_addr_o <= wr_addr_nxt;
         trig_o  <= enter_post;
         wr_en_o <= (state_nxt == ST_PRE) || (state_nxt == ST_WAIT) || (state_nxt == ST_POST);
         busy_o  <= (state_nxt == ST_PRE) || (state_nxt == ST_WAIT) ||
                    (state_nxt == ST_POST) || (state_nxt == ST_HOLD);
         done_o  <= (state_nxt == ST_DONE);
         state_o <= state_nxt;
      end
   end

endmodule

// File: tb/tb_trig_acq_ctrl.sv
// Directed bench for the acquisition sequencer with a trigger/done event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_trig_acq_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // main instance (default widths)
   logic        arm = 0, abort = 0, cont = 0, trig = 0;
   logic [13:0] pre_len = 0, post_len = 0;
   logic [15:0] holdoff = 0;
   logic        wr_en, trig_p, busy, done;
   logic [13:0] wr_addr, trig_addr;
   logic [2:0]  state;

   // narrow-address instance for the wrap case
   logic        arm2 = 0, abort2 = 0, cont2 = 0, trig2 = 0;
   logic [13:0] pre2 = 0, post2 = 0;
   logic [15:0] hold2 = 0;
   logic        wr_en2, trig_p2, busy2, done2;
   logic [3:0]  wr_addr2, trig_addr2;
   logic [2:0]  state2;

   typedef struct {
      int kind;   // 0 = trigger pulse, 1 = done rise
      int cyc;
      int addr;
   } ev_t;
   ev_t exp_q[$];

   trig_acq_ctrl dut (
      .adc_clk(clk), .adc_rstn(rstn), .arm_i(arm), .abort_i(abort), .cont_i(cont),
      .trig_i(trig), .pre_len_i(pre_len), .post_len_i(post_len), .holdoff_i(holdoff),
      .wr_en_o(wr_en), .wr_addr_o(wr_addr), .trig_addr_o(trig_addr), .trig_o(trig_p),
      .busy_o(busy), .done_o(done), .state_o(state)
   );

   trig_acq_ctrl #(.ADDR_W(4)) dut2 (
      .adc_clk(clk), .adc_rstn(rstn), .arm_i(arm2), .abort_i(abort2), .cont_i(cont2),
      .trig_i(trig2), .pre_len_i(pre2), .post_len_i(post2), .holdoff_i(hold2),
      .wr_en_o(wr_en2), .wr_addr_o(wr_addr2), .trig_addr_o(trig_addr2), .trig_o(trig_p2),
      .busy_o(busy2), .done_o(done2), .state_o(state2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push(input int kind, input int c, input int addr);
      ev_t e;
      e.kind = kind; e.cyc = c; e.addr = addr;
      exp_q.push_back(e);
   endtask

   task automatic score(input int kind, input int addr);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL ev_unexpected kind=%0d cyc=%0d addr=%0d want=none", kind, cyc, addr);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.addr != addr) begin
            errors++;
            $display("FAIL ev_kind%0d got cyc=%0d addr=%0d want kind=%0d cyc=%0d addr=%0d",
                     kind, cyc, addr, e.kind, e.cyc, e.addr);
         end
      end
   endtask

   // Monitor: every trig_o cycle and every done_o rise consumes one expected event
   logic done_d = 1'b0;
   always @(negedge clk) begin
      if (!rstn) begin
         done_d = 1'b0;
      end else begin
         if (trig_p) score(0, int'(trig_addr));
         if (done && !done_d) score(1, int'(wr_addr));
         done_d = done;
      end
   end

   initial begin
      int t0;
      // reset state
      #12;
      chk("rst_state", state, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_busy_done", {busy, done, trig_p}, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      tick();

      // single shot: pre=4 post=3, trigger rises at cycle 8
      t0 = cyc;
      pre_len = 4; post_len = 3; cont = 0; holdoff = 0; arm = 1;
      push(0, t0 + 9, 8); push(1, t0 + 12, 11);
      tick(); arm = 0;
      chk("s1_pre_state", state, 1);
      chk("s1_pre_wr_en", wr_en, 1);
      chk("s1_pre_busy", busy, 1);
      goto(t0 + 4); chk("s1_pre_last", state, 1);
      goto(t0 + 5); chk("s1_wait", state, 2); chk("s1_wait_addr", wr_addr, 4);
      goto(t0 + 8); trig = 1;
      goto(t0 + 9); chk("s1_post", state, 3);
      goto(t0 + 11); chk("s1_post_wr_en", wr_en, 1);
      goto(t0 + 12);
      chk("s1_done_state", state, 5); chk("s1_done", done, 1);
      chk("s1_done_wr_en", wr_en, 0); chk("s1_done_busy", busy, 0);
      trig = 0;

      // trigger pulse during PRE is ignored; a later edge in WAIT captures
      t0 = cyc;
      pre_len = 4; post_len = 3; arm = 1;
      push(0, t0 + 11, 21); push(1, t0 + 14, 24);
      tick(); arm = 0;
      goto(t0 + 2); trig = 1;
      goto(t0 + 3); trig = 0;
      goto(t0 + 10); chk("s2_still_wait", state, 2); trig = 1;
      goto(t0 + 14); chk("s2_done", state, 5); trig = 0;

      // trigger already high through arm: needs a fresh rise
      trig = 1; tick();
      t0 = cyc;
      pre_len = 2; post_len = 1; arm = 1;
      push(0, t0 + 8, 31); push(1, t0 + 9, 32);
      tick(); arm = 0;
      goto(t0 + 6); chk("s3_held_wait", state, 2); trig = 0;
      goto(t0 + 7); chk("s3_low_wait", state, 2); trig = 1;
      goto(t0 + 9); chk("s3_done", state, 5); trig = 0;

      // pre=0 goes straight to WAIT; post=0 gives one POST cycle
      t0 = cyc;
      pre_len = 0; post_len = 0; arm = 1;
      push(0, t0 + 3, 34); push(1, t0 + 4, 35);
      tick(); arm = 0;
      chk("s4_pre0_wait", state, 2); chk("s4_wr_en", wr_en, 1);
      goto(t0 + 2); trig = 1;
      goto(t0 + 3); chk("s4_post", state, 3);
      goto(t0 + 4); chk("s4_done_after_1", state, 5); trig = 0;

      // continuous with hold-off, then abort in the second POST cycle
      t0 = cyc;
      cont = 1; pre_len = 2; post_len = 2; holdoff = 3; arm = 1;
      push(0, t0 + 5, 39); push(0, t0 + 14, 45);
      tick(); arm = 0;
      goto(t0 + 4); trig = 1;
      goto(t0 + 5); trig = 0;
      goto(t0 + 7); chk("s5_hold_first", state, 4); chk("s5_hold_wr_en", wr_en, 0);
      goto(t0 + 9); chk("s5_hold_last", state, 4); chk("s5_hold_wr_en3", wr_en, 0);
      goto(t0 + 10); chk("s5_rearm_pre", state, 1); chk("s5_rearm_wr_en", wr_en, 1);
      goto(t0 + 13); trig = 1;
      goto(t0 + 15); chk("s5_post2", state, 3); abort = 1;
      tick(); abort = 0; trig = 0;
      chk("s5_abort_idle", state, 0); chk("s5_abort_wr_en", wr_en, 0);
      chk("s5_abort_done", done, 0); chk("s5_abort_busy", busy, 0);
      chk("s5_abort_addr", wr_addr, 47); chk("s5_abort_taddr", trig_addr, 45);
      goto(t0 + 18); chk("s5_addr_held", wr_addr, 47);

      // clean capture after abort; arm while busy has no effect
      t0 = cyc;
      cont = 0; pre_len = 1; post_len = 2; holdoff = 0; arm = 1;
      push(0, t0 + 3, 49); push(1, t0 + 5, 51);
      tick(); arm = 0;
      goto(t0 + 2); trig = 1;
      goto(t0 + 3); arm = 1; pre_len = 7;
      tick(); arm = 0;
      goto(t0 + 5); chk("s6_done", state, 5); trig = 0;

      // async reset mid-WAIT clears outputs without a clock edge
      t0 = cyc;
      pre_len = 0; post_len = 2; arm = 1;
      tick(); arm = 0;
      goto(t0 + 2); chk("s7_wait", state, 2);
      #2 rstn = 0;
      #1;
      chk("s7_rst_state", state, 0); chk("s7_rst_wr_en", wr_en, 0);
      chk("s7_rst_addr", wr_addr, 0); chk("s7_rst_taddr", trig_addr, 0);
      chk("s7_rst_busy", busy, 0);
      tick(); rstn = 1; tick();

      chk("sb_empty", exp_q.size(), 0);

      // 4-bit address: 20-sample capture wraps 15 -> 0
      t0 = cyc;
      pre2 = 9; post2 = 10; arm2 = 1;
      tick(); arm2 = 0;
      goto(t0 + 10); trig2 = 1;
      goto(t0 + 11);
      chk("w_trig", trig_p2, 1); chk("w_taddr", trig_addr2, 10);
      goto(t0 + 16); chk("w_addr15", wr_addr2, 15);
      goto(t0 + 17); chk("w_addr0", wr_addr2, 0);
      goto(t0 + 21); chk("w_done", done2, 1); chk("w_end_addr", wr_addr2, 4);
      trig2 = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
